operand_fetch: RTL and testbench
================================

# operand_fetch

Operand-fetch stage sitting directly upstream of the 16×16 three-read/two-write register file. It accepts decoded instructions from decode, drives the file's Rd/Rs/Rm read addresses, and presents the three operands to execute one cycle later with a valid/ready handshake. The file's reads are registered and sample the old value on a same-edge write. This block therefore forwards writeback data that lands on the sampling edge, so execute always sees the architecturally current value.

## Interface
- DATA_W, 16: register data width
- ADDR_W, 4: register address width
- TAG_W, 8: opaque decode payload (opcode/immediate selector) passed through
- Clock  in  1  sole clock, rising edge
- Reset_n  in  1  synchronous, active-low reset
- Flush  in  1  synchronous kill of the held instruction
- Dec_Valid  in  1  decode offers an instruction
- Dec_Ready  out  1  stage accepts this cycle
- Dec_Rd_Addr, Dec_Rs_Addr, Dec_Rm_Addr  in  ADDR_W each  source register numbers
- Dec_Tag  in  TAG_W  payload
- Rd_Addr, Rs_Addr, Rm_Addr  out  ADDR_W each  to register file read ports
- Rd_Out, Rs_Out, Rm_Out  in  DATA_W each  register file registered read data
- Wb_Rd_Wen, Wb_Rs_Wen  in  1 each  the same write enables driven into the file
- Wb_Rd_Addr, Wb_Rs_Addr  in  ADDR_W each  write addresses
- Wb_Rd_Data, Wb_Rs_Data  in  DATA_W each  write data
- Ex_Valid  out  1  operands valid
- Ex_Ready  in  1  execute consumes
- Ex_Rd_Data, Ex_Rs_Data, Ex_Rm_Data  out  DATA_W each  operands
- Ex_Rd_Addr, Ex_Rs_Addr, Ex_Rm_Addr  out  ADDR_W each  held addresses
- Ex_Tag  out  TAG_W  held payload

## Operation
- Dec_Ready = !Flush && (!Ex_Valid || Ex_Ready).
- Address mux (combinational): if Dec_Ready, drive the Dec_*_Addr values to Rd/Rs/Rm_Addr. Otherwise drive the held Ex_*_Addr values. The file therefore re-reads the held instruction on every stall edge.
- On each edge with Dec_Valid && Dec_Ready: capture addresses and tag into the Ex_* registers and set Ex_Valid=1.
- Else, on Ex_Valid && Ex_Ready: clear Ex_Valid. Flush=1 clears Ex_Valid regardless of other inputs.
- Forwarding capture, per read port P ∈ {Rd,Rs,Rm}, on every edge: compare the address being driven on P_Addr this cycle with both write ports.
  - Wb_Rs_Wen hit: fwd_P=1, fwd_data_P=Wb_Rs_Data. Rs wins on a double hit, matching the file's write priority.
  - Else Wb_Rd_Wen hit: fwd_P=1, fwd_data_P=Wb_Rd_Data.
  - Else fwd_P=0.
- Operand output: Ex_P_Data = fwd_P ? fwd_data_P : P_Out. This is a pure mux with no extra register stage.
- While stalled, each edge re-evaluates the forward against the held address. A later write to a held source therefore updates the operand in the following cycle.
- Two operands with equal addresses each forward independently and yield identical data.

## Timing
- Reset (Reset_n=0 at an edge): Ex_Valid=0, fwd flags=0, fwd data=0, Ex_*_Addr=0, Ex_Tag=0. Dec_Ready follows its equation with Ex_Valid=0, so it is 1 unless Flush=1.
- Ex_Data values are don't-care while Ex_Valid=0.
- Latency: an instruction accepted at edge N is presented with Ex_Valid=1 throughout cycle N+1.
- Throughput: one instruction per cycle while Ex_Ready=1.
- Handshake: once Ex_Valid=1, Ex_Tag and Ex_*_Addr stay stable until Ex_Ready=1. Ex_*_Data may change only because of a write to a held source.
- Accept and consume on the same edge: the new instruction replaces the old and Ex_Valid stays 1.
- Flush and Dec_Valid together: nothing is accepted and Ex_Valid=0 next cycle.
- Reset mid-stall drops the held instruction; no operand is delivered.
- Writes during reset are not forwarded.

## Structure
- Shared package cpu_pkg holds the DATA_W/ADDR_W constants and a reg_addr_t typedef; the register file uses the same package.
- One sub-module, fwd_sel, is instantiated three times. It does the per-port compare, priority select and capture register (inputs: read address, both write ports; outputs: fwd flag, fwd data). Muxing with P_Out is done in the parent.

## Test plan
- Basic fetch: preload R3=0x1234, R5=0xBEEF, R7=0x0001. Issue Rd=3, Rs=5, Rm=7, tag 0x42 at edge N. Required next cycle: Ex_Valid=1, operands 0x1234/0xBEEF/0x0001, Ex_Tag=0x42.
- Same-edge forward: issue Rs_Addr=5 while Wb_Rd_Wen writes R5=0xCAFE on the same edge. Required: Ex_Rs_Data=0xCAFE, not the old 0xBEEF.
- Double-write priority: Wb_Rd and Wb_Rs both write R2 (0x1111 / 0x2222) on the issue edge of Rm=2. Required: Ex_Rm_Data=0x2222.
- Stall update: hold Ex_Ready=0 for 3 cycles with Rd=4 held. Write R4=0x00AA in stall cycle 2. Required: Ex_Rd_Data=0x00AA from the next cycle, Ex_Tag unchanged, Dec_Ready=0 throughout.
- Back-to-back: issue 4 instructions on consecutive cycles with Ex_Ready=1. Required: 4 consecutive Ex_Valid cycles, correct operands each, no bubbles.
- Flush/reset: Flush with Dec_Valid=1 leaves Ex_Valid=0 next cycle. Reset_n=0 mid-stall leaves Ex_Valid=0 and Dec_Ready=1 after the reset edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the register file and the stages around it.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int TAG_W  = 8;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [TAG_W-1:0]  tag_t;

  // One register-file write port as seen by the forwarding logic.
  typedef struct packed {
    logic      wen;
    reg_addr_t addr;
    reg_data_t data;
  } wr_port_t;

  // Instruction fields held in the execute-facing register.
  typedef struct packed {
    reg_addr_t rd;
    reg_addr_t rs;
    reg_addr_t rm;
    tag_t      tag;
  } ex_hold_t;

  function automatic logic wr_hit(input wr_port_t w, input reg_addr_t a);
    return w.wen && (w.addr == a);
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Decode / register-file / writeback / execute signals around the operand-fetch stage.
interface operand_fetch_if;
  import cpu_pkg::*;

  logic      Dec_Valid;
  logic      Dec_Ready;
  reg_addr_t Dec_Rd_Addr, Dec_Rs_Addr, Dec_Rm_Addr;
  tag_t      Dec_Tag;

  reg_addr_t Rd_Addr, Rs_Addr, Rm_Addr;
  reg_data_t Rd_Out, Rs_Out, Rm_Out;

  logic      Wb_Rd_Wen, Wb_Rs_Wen;
  reg_addr_t Wb_Rd_Addr, Wb_Rs_Addr;
  reg_data_t Wb_Rd_Data, Wb_Rs_Data;

  logic      Ex_Valid;
  logic      Ex_Ready;
  reg_data_t Ex_Rd_Data, Ex_Rs_Data, Ex_Rm_Data;
  reg_addr_t Ex_Rd_Addr, Ex_Rs_Addr, Ex_Rm_Addr;
  tag_t      Ex_Tag;

  // Surrounding pipeline: decode, register file, writeback and execute.
  modport master (
    output Dec_Valid, Dec_Rd_Addr, Dec_Rs_Addr, Dec_Rm_Addr, Dec_Tag,
    output Rd_Out, Rs_Out, Rm_Out,
    output Wb_Rd_Wen, Wb_Rs_Wen, Wb_Rd_Addr, Wb_Rs_Addr, Wb_Rd_Data, Wb_Rs_Data,
    output Ex_Ready,
    input  Dec_Ready, Rd_Addr, Rs_Addr, Rm_Addr,
    input  Ex_Valid, Ex_Rd_Data, Ex_Rs_Data, Ex_Rm_Data,
    input  Ex_Rd_Addr, Ex_Rs_Addr, Ex_Rm_Addr, Ex_Tag
  );

  // The operand-fetch stage itself.
  modport slave (
    input  Dec_Valid, Dec_Rd_Addr, Dec_Rs_Addr, Dec_Rm_Addr, Dec_Tag,
    input  Rd_Out, Rs_Out, Rm_Out,
    input  Wb_Rd_Wen, Wb_Rs_Wen, Wb_Rd_Addr, Wb_Rs_Addr, Wb_Rd_Data, Wb_Rs_Data,
    input  Ex_Ready,
    output Dec_Ready, Rd_Addr, Rs_Addr, Rm_Addr,
    output Ex_Valid, Ex_Rd_Data, Ex_Rs_Data, Ex_Rm_Data,
    output Ex_Rd_Addr, Ex_Rs_Addr, Ex_Rm_Addr, Ex_Tag
  );
endinterface

// File: rtl/fwd_sel.sv
// Per-read-port forward capture: on each edge, record whether a write lands on the
// address being read this cycle, so the stale registered read can be overridden.
module fwd_sel
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  reg_addr_t rd_addr,
  input  wr_port_t  wb_rd,
  input  wr_port_t  wb_rs,
  output logic      fwd,
  output reg_data_t fwd_data
);

  logic      fwd_d, fwd_q;
  reg_data_t fwd_data_d, fwd_data_q;

  // NOTE: defaults first so every path assigns each output; otherwise a latch is inferred.
  always_comb begin
    fwd_d      = 1'b0;
    fwd_data_d = '0;
    if (wr_hit(wb_rs, rd_addr)) begin
      fwd_d      = 1'b1;
      fwd_data_d = wb_rs.data;
    end else if (wr_hit(wb_rd, rd_addr)) begin
      fwd_d      = 1'b1;
      fwd_data_d = wb_rd.data;
    end
  end

  // NOTE: non-blocking in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  assign fwd      = fwd_q;
  assign fwd_data = fwd_data_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: drives register-file read addresses, holds one instruction for
// execute and forwards writeback data that lands on the file's sampling edge.
module operand_fetch
  import cpu_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Flush,
  operand_fetch_if.slave   bus
);

  logic      ex_valid_d, ex_valid_q;
  ex_hold_t  ex_d, ex_q;
  logic      dec_ready;
  reg_addr_t rd_addr, rs_addr, rm_addr;
  wr_port_t  wb_rd, wb_rs;
  logic      fwd_rd, fwd_rs, fwd_rm;
  reg_data_t fwd_data_rd, fwd_data_rs, fwd_data_rm;

  always_comb begin
    wb_rd = '{wen: bus.Wb_Rd_Wen, addr: bus.Wb_Rd_Addr, data: bus.Wb_Rd_Data};
    wb_rs = '{wen: bus.Wb_Rs_Wen, addr: bus.Wb_Rs_Addr, data: bus.Wb_Rs_Data};
  end

  // While stalled the held addresses go back to the file, so it re-reads every edge.
  always_comb begin
    dec_ready = !Flush && (!ex_valid_q || bus.Ex_Ready);
    if (dec_ready) begin
      rd_addr = bus.Dec_Rd_Addr;
      rs_addr = bus.Dec_Rs_Addr;
      rm_addr = bus.Dec_Rm_Addr;
    end else begin
      rd_addr = ex_q.rd;
      rs_addr = ex_q.rs;
      rm_addr = ex_q.rm;
    end
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_d       = ex_q;
    if (Flush) begin
      ex_valid_d = 1'b0;
    end else if (bus.Dec_Valid && dec_ready) begin
      ex_valid_d = 1'b1;
      ex_d       = '{rd: bus.Dec_Rd_Addr, rs: bus.Dec_Rs_Addr,
                     rm: bus.Dec_Rm_Addr, tag: bus.Dec_Tag};
    end else if (ex_valid_q && bus.Ex_Ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_q       <= ex_d;
    end
  end

  fwd_sel u_fwd_rd (.clk(Clock), .rst_n(Reset_n), .rd_addr(rd_addr), .wb_rd(wb_rd),
                    .wb_rs(wb_rs), .fwd(fwd_rd), .fwd_data(fwd_data_rd));
  fwd_sel u_fwd_rs (.clk(Clock), .rst_n(Reset_n), .rd_addr(rs_addr), .wb_rd(wb_rd),
                    .wb_rs(wb_rs), .fwd(fwd_rs), .fwd_data(fwd_data_rs));
  fwd_sel u_fwd_rm (.clk(Clock), .rst_n(Reset_n), .rd_addr(rm_addr), .wb_rd(wb_rd),
                    .wb_rs(wb_rs), .fwd(fwd_rm), .fwd_data(fwd_data_rm));

  always_comb begin
    bus.Dec_Ready  = dec_ready;
    bus.Rd_Addr    = rd_addr;
    bus.Rs_Addr    = rs_addr;
    bus.Rm_Addr    = rm_addr;
    bus.Ex_Valid   = ex_valid_q;
    bus.Ex_Rd_Addr = ex_q.rd;
    bus.Ex_Rs_Addr = ex_q.rs;
    bus.Ex_Rm_Addr = ex_q.rm;
    bus.Ex_Tag     = ex_q.tag;
    bus.Ex_Rd_Data = fwd_rd ? fwd_data_rd : bus.Rd_Out;
    bus.Ex_Rs_Data = fwd_rs ? fwd_data_rs : bus.Rs_Out;
    bus.Ex_Rm_Data = fwd_rm ? fwd_data_rm : bus.Rm_Out;
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural 16x16 register file
// (registered reads, old value on same-edge write, Rs write port has priority).
module tb_operand_fetch;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic flush;
  int   total = 0;
  int   bad   = 0;

  operand_fetch_if bus ();

  operand_fetch dut (
    .Clock   (clk),
    .Reset_n (reset_n),
    .Flush   (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  reg_data_t mem [16];

  always @(posedge clk) begin
    bus.Rd_Out <= mem[bus.Rd_Addr];
    bus.Rs_Out <= mem[bus.Rs_Addr];
    bus.Rm_Out <= mem[bus.Rm_Addr];
    if (bus.Wb_Rd_Wen) mem[bus.Wb_Rd_Addr] <= bus.Wb_Rd_Data;
    if (bus.Wb_Rs_Wen) mem[bus.Wb_Rs_Addr] <= bus.Wb_Rs_Data;
  end

  // Back-to-back table: addresses, tag and hand-computed operands.
  reg_addr_t b_rd  [4] = '{4'd3, 4'd4, 4'd7, 4'd2};
  reg_addr_t b_rs  [4] = '{4'd5, 4'd2, 4'd7, 4'd4};
  reg_addr_t b_rm  [4] = '{4'd7, 4'd3, 4'd5, 4'd4};
  tag_t      b_tag [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
  reg_data_t e_rd  [4] = '{16'h1234, 16'h00AA, 16'h0001, 16'h2222};
  reg_data_t e_rs  [4] = '{16'hCAFE, 16'h2222, 16'h0001, 16'h00AA};
  reg_data_t e_rm  [4] = '{16'h0001, 16'h1234, 16'hCAFE, 16'h00AA};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_dec(input logic v, input reg_addr_t rd, input reg_addr_t rs,
                         input reg_addr_t rm, input tag_t tag);
    bus.Dec_Valid   = v;
    bus.Dec_Rd_Addr = rd;
    bus.Dec_Rs_Addr = rs;
    bus.Dec_Rm_Addr = rm;
    bus.Dec_Tag     = tag;
  endtask

  task automatic set_wb(input logic rdw, input reg_addr_t rda, input reg_data_t rdd,
                        input logic rsw, input reg_addr_t rsa, input reg_data_t rsd);
    bus.Wb_Rd_Wen  = rdw;
    bus.Wb_Rd_Addr = rda;
    bus.Wb_Rd_Data = rdd;
    bus.Wb_Rs_Wen  = rsw;
    bus.Wb_Rs_Addr = rsa;
    bus.Wb_Rs_Data = rsd;
  endtask

  initial begin
    reset_n      = 1'b0;
    flush        = 1'b0;
    bus.Ex_Ready = 1'b1;
    set_dec(1'b0, 4'd0, 4'd0, 4'd0, 8'h00);

    // Preload the file through the write ports while in reset.
    set_wb(1'b1, 4'd3, 16'h1234, 1'b1, 4'd5, 16'hBEEF);
    tick();
    set_wb(1'b1, 4'd7, 16'h0001, 1'b1, 4'd4, 16'h0044);
    tick();
    set_wb(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    reset_n = 1'b1;
    #1;
    check("reset_ex_valid", 32'(bus.Ex_Valid), 32'd0);
    check("reset_dec_ready", 32'(bus.Dec_Ready), 32'd1);
    check("reset_ex_tag", 32'(bus.Ex_Tag), 32'h0);
    check("reset_ex_rd_addr", 32'(bus.Ex_Rd_Addr), 32'h0);

    // Basic fetch.
    set_dec(1'b1, 4'd3, 4'd5, 4'd7, 8'h42);
    tick();
    check("basic_valid", 32'(bus.Ex_Valid), 32'd1);
    check("basic_rd", 32'(bus.Ex_Rd_Data), 32'h1234);
    check("basic_rs", 32'(bus.Ex_Rs_Data), 32'hBEEF);
    check("basic_rm", 32'(bus.Ex_Rm_Data), 32'h0001);
    check("basic_tag", 32'(bus.Ex_Tag), 32'h42);

    // Same-edge forward from the Rd write port.
    set_dec(1'b1, 4'd3, 4'd5, 4'd7, 8'h43);
    set_wb(1'b1, 4'd5, 16'hCAFE, 1'b0, 4'd0, 16'h0);
    tick();
    set_wb(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    check("fwd_rs", 32'(bus.Ex_Rs_Data), 32'hCAFE);
    check("fwd_rd_unaffected", 32'(bus.Ex_Rd_Data), 32'h1234);
    check("fwd_tag", 32'(bus.Ex_Tag), 32'h43);

    // Double write on the issue edge: Rs port wins.
    set_dec(1'b1, 4'd5, 4'd3, 4'd2, 8'h44);
    set_wb(1'b1, 4'd2, 16'h1111, 1'b1, 4'd2, 16'h2222);
    tick();
    set_wb(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    check("dbl_rm", 32'(bus.Ex_Rm_Data), 32'h2222);
    check("dbl_rd_from_file", 32'(bus.Ex_Rd_Data), 32'hCAFE);
    check("dbl_rs", 32'(bus.Ex_Rs_Data), 32'h1234);

    // Stall with a write to a held source in stall cycle 2.
    set_dec(1'b1, 4'd4, 4'd2, 4'd7, 8'h55);
    tick();
    bus.Ex_Ready = 1'b0;
    set_dec(1'b1, 4'd9, 4'd9, 4'd9, 8'h66);
    #1;
    check("stall1_valid", 32'(bus.Ex_Valid), 32'd1);
    check("stall1_dec_ready", 32'(bus.Dec_Ready), 32'd0);
    check("stall1_rd_addr_held", 32'(bus.Rd_Addr), 32'd4);
    check("stall1_rd", 32'(bus.Ex_Rd_Data), 32'h0044);
    check("stall1_rs", 32'(bus.Ex_Rs_Data), 32'h2222);
    tick();
    check("stall2_dec_ready", 32'(bus.Dec_Ready), 32'd0);
    check("stall2_tag", 32'(bus.Ex_Tag), 32'h55);
    check("stall2_rd", 32'(bus.Ex_Rd_Data), 32'h0044);
    set_wb(1'b0, 4'd0, 16'h0, 1'b1, 4'd4, 16'h00AA);
    tick();
    set_wb(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    check("stall3_rd_updated", 32'(bus.Ex_Rd_Data), 32'h00AA);
    check("stall3_tag", 32'(bus.Ex_Tag), 32'h55);
    check("stall3_rd_addr", 32'(bus.Ex_Rd_Addr), 32'd4);
    check("stall3_dec_ready", 32'(bus.Dec_Ready), 32'd0);
    bus.Ex_Ready = 1'b1;
    bus.Dec_Valid = 1'b0;
    tick();
    check("consume_valid", 32'(bus.Ex_Valid), 32'd0);

    // Back-to-back, no bubbles.
    for (int i = 0; i < 4; i++) begin
      set_dec(1'b1, b_rd[i], b_rs[i], b_rm[i], b_tag[i]);
      tick();
      check($sformatf("b2b%0d_valid", i), 32'(bus.Ex_Valid), 32'd1);
      check($sformatf("b2b%0d_rd", i), 32'(bus.Ex_Rd_Data), 32'(e_rd[i]));
      check($sformatf("b2b%0d_rs", i), 32'(bus.Ex_Rs_Data), 32'(e_rs[i]));
      check($sformatf("b2b%0d_rm", i), 32'(bus.Ex_Rm_Data), 32'(e_rm[i]));
      check($sformatf("b2b%0d_tag", i), 32'(bus.Ex_Tag), 32'(b_tag[i]));
    end
    bus.Dec_Valid = 1'b0;
    tick();
    check("b2b_drain_valid", 32'(bus.Ex_Valid), 32'd0);

    // Flush with Dec_Valid: nothing accepted, held instruction killed.
    set_dec(1'b1, 4'd3, 4'd5, 4'd7, 8'h77);
    tick();
    check("pre_flush_valid", 32'(bus.Ex_Valid), 32'd1);
    flush = 1'b1;
    set_dec(1'b1, 4'd4, 4'd4, 4'd4, 8'h78);
    #1;
    check("flush_dec_ready", 32'(bus.Dec_Ready), 32'd0);
    check("flush_rd_addr_held", 32'(bus.Rd_Addr), 32'd3);
    tick();
    flush = 1'b0;
    bus.Dec_Valid = 1'b0;
    check("flush_valid", 32'(bus.Ex_Valid), 32'd0);
    check("flush_tag_kept", 32'(bus.Ex_Tag), 32'h77);

    // Reset mid-stall, with a file write during reset.
    set_dec(1'b1, 4'd5, 4'd2, 4'd4, 8'h88);
    tick();
    bus.Ex_Ready  = 1'b0;
    bus.Dec_Valid = 1'b0;
    #1;
    check("rst_stall_valid", 32'(bus.Ex_Valid), 32'd1);
    check("rst_stall_dec_ready", 32'(bus.Dec_Ready), 32'd0);
    reset_n = 1'b0;
    set_wb(1'b1, 4'd3, 16'h5555, 1'b0, 4'd0, 16'h0);
    tick();
    reset_n = 1'b1;
    set_wb(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    #1;
    check("rst_mid_valid", 32'(bus.Ex_Valid), 32'd0);
    check("rst_mid_dec_ready", 32'(bus.Dec_Ready), 32'd1);
    check("rst_mid_tag", 32'(bus.Ex_Tag), 32'h0);
    check("rst_mid_rd_addr", 32'(bus.Ex_Rd_Addr), 32'h0);
    bus.Ex_Ready = 1'b1;
    set_dec(1'b1, 4'd3, 4'd3, 4'd3, 8'h99);
    tick();
    bus.Dec_Valid = 1'b0;
    check("post_rst_valid", 32'(bus.Ex_Valid), 32'd1);
    check("post_rst_rd", 32'(bus.Ex_Rd_Data), 32'h5555);
    check("post_rst_tag", 32'(bus.Ex_Tag), 32'h99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
